matrix_write_packer: RTL

- Serial-to-parallel front end for the multi-matrix store's write port.
- Accepts matrix dimensions, then elements one per handshake (from the keypad/UART parser).
- Zero-pads the unused addresses and issues a single-cycle write request to the store.
- Captures the allocated index and overwrite flag that the store returns, and reports completion upstream.

---
 rtl/matrix_write_packer_if.sv | 44 ++++
 rtl/matrix_write_packer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/matrix_write_packer_if.sv
// Bundle between the element source / matrix store and the write packer.
// The master side is the environment; the slave side is the packer itself.
interface matrix_write_packer_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_SIZE     = 5,
  parameter int unsigned MATRIX_IDX_W = 3
);
  localparam int unsigned DEPTH = MAX_SIZE * MAX_SIZE;
  localparam int unsigned DIM_W = 3;

  logic                          start;
  logic [DIM_W-1:0]              in_row;
  logic [DIM_W-1:0]              in_col;
  logic                          abort;
  logic                          elem_valid;
  logic [DATA_WIDTH-1:0]         elem_data;
  logic                          elem_ready;
  logic                          wr_en;
  logic [DIM_W-1:0]              write_row;
  logic [DIM_W-1:0]              write_col;
  logic [DEPTH*DATA_WIDTH-1:0]   data_flat;
  logic                          wr_ready;
  logic [MATRIX_IDX_W-1:0]       wr_alloc_idx;
  logic                          wr_overwrite;
  logic                          busy;
  logic                          done;
  logic [MATRIX_IDX_W-1:0]       done_idx;
  logic                          done_overwrite;
  logic                          err_dim;

  modport master (
    output start, in_row, in_col, abort, elem_valid, elem_data,
           wr_ready, wr_alloc_idx, wr_overwrite,
    input  elem_ready, wr_en, write_row, write_col, data_flat,
           busy, done, done_idx, done_overwrite, err_dim
  );

  modport slave (
    input  start, in_row, in_col, abort, elem_valid, elem_data,
           wr_ready, wr_alloc_idx, wr_overwrite,
    output elem_ready, wr_en, write_row, write_col, data_flat,
           busy, done, done_idx, done_overwrite, err_dim
  );
endinterface

// File: rtl/matrix_write_packer.sv
// Collects a matrix one element at a time, zero-pads the buffer and issues a
// single write request to the matrix store, then reports the allocated slot.
module matrix_write_packer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_SIZE     = 5,
  parameter int unsigned MATRIX_IDX_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  matrix_write_packer_if.slave bus
);
  localparam int unsigned DEPTH = MAX_SIZE * MAX_SIZE;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DIM_W = 3;
  localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(MAX_SIZE);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, WR, CAP} state_t;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, total_q;
  logic [DIM_W-1:0]                      row_q, col_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]      buf_q;
  logic [MATRIX_IDX_W-1:0]               done_idx_q;
  logic                                  done_ovw_q;
  logic elem_ready_q, wr_en_q, busy_q, done_q, err_dim_q;
  logic elem_ready_d, wr_en_d, busy_d, done_d, err_dim_d;
  logic start_go, accept, dims_ok;

  assign dims_ok = (bus.in_row != '0) && (bus.in_row <= MAX_DIM) &&
                   (bus.in_col != '0) && (bus.in_col <= MAX_DIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-output decode; abort beats start in IDLE
  always_comb begin
    state_d   = state_q;
    err_dim_d = 1'b0;
    start_go  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (dims_ok) begin
            state_d  = LOAD;
            start_go = 1'b1;
          end else begin
            err_dim_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.elem_valid && elem_ready_q) begin
          accept = 1'b1;
          if (cnt_q == total_q - CNT_W'(1)) state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.abort)         state_d = IDLE;
        else if (bus.wr_ready) state_d = WR;
      end
      WR:      state_d = CAP;
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    elem_ready_d = (state_d == LOAD);
    wr_en_d      = (state_d == WR);
    busy_d       = (state_d != IDLE);
    done_d       = (state_q == CAP);
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_dim_q    <= 1'b0;
      row_q        <= DIM_W'(1);
      col_q        <= DIM_W'(1);
      total_q      <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      done_idx_q   <= '0;
      done_ovw_q   <= 1'b0;
    end else begin
      elem_ready_q <= elem_ready_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_dim_q    <= err_dim_d;
      if (start_go) begin
        row_q   <= bus.in_row;
        col_q   <= bus.in_col;
        total_q <= CNT_W'(bus.in_row) * CNT_W'(bus.in_col);
        cnt_q   <= '0;
        buf_q   <= '0;
      end
      if (accept) begin
        buf_q[cnt_q] <= bus.elem_data;
        cnt_q        <= cnt_q + CNT_W'(1);
      end
      // Store response is valid only in the cycle after the write edge
      if (state_q == CAP) begin
        done_idx_q <= bus.wr_alloc_idx;
        done_ovw_q <= bus.wr_overwrite;
      end
    end
  end

  assign bus.elem_ready     = elem_ready_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err_dim        = err_dim_q;
  assign bus.write_row      = row_q;
  assign bus.write_col      = col_q;
  assign bus.data_flat      = buf_q;
  assign bus.done_idx       = done_idx_q;
  assign bus.done_overwrite = done_ovw_q;
endmodule
